// File: rtl/ring_osc_pkg.sv
// Shared types and default widths for the ring oscillator frequency counter.
package ring_osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_DONE
  } state_e;

  localparam int CNT_W_DEF  = 16;
  localparam int GATE_W_DEF = 12;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ring_osc_edge_sync.sv
// Brings the asynchronous ring output into the clk domain and flags each
// rising edge with a single-cycle pulse.
module osc_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic osc_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a true shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= osc_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~hist_q;

endmodule

// File: rtl/ring_osc_counter.sv
// Ring oscillator measurement controller: enables the ring, waits for it to
// settle, counts synchronized rising edges over a gate window, latches result.
// Build option: RING_OSC_CNT_SAT_EN makes the edge counter saturate instead of wrap.
module ring_osc_counter
  import ring_osc_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int GATE_W        = GATE_W_DEF,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              osc_in,
  output logic              ring_nrst,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              ovf
);

  // One timer serves both the settle phase and the gate window.
  localparam int TMR_W = max_int(GATE_W, $clog2(SETTLE_CYCLES + 1));
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);

  state_e             state_q;
  logic [TMR_W-1:0]   timer_q;
  logic [TMR_W-1:0]   gate_last;
  logic [GATE_W-1:0]  gate_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               ovf_flag_q;
  logic               ovf_flag_d;
  logic [CNT_W-1:0]   count_q;
  logic               ovf_q;
  logic               done_q;
  logic               busy_q;
  logic               ring_nrst_q;
  logic               edge_pulse;

  osc_edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .osc_i  (osc_in),
    .edge_o (edge_pulse)
  );

  assign gate_last = TMR_W'(gate_q) - TMR_W'(1);

  // NOTE: always_comb assigns every output a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    if (state_q == ST_COUNT && edge_pulse) begin
      if (&cnt_q) begin
        ovf_flag_d = 1'b1;
`ifdef RING_OSC_CNT_SAT_EN
        cnt_d = cnt_q;
`else
        cnt_d = '0;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      gate_q      <= '0;
      cnt_q       <= '0;
      ovf_flag_q  <= 1'b0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ring_nrst_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_SETTLE;
            gate_q      <= gate_len;
            timer_q     <= '0;
            cnt_q       <= '0;
            ovf_flag_q  <= 1'b0;
            busy_q      <= 1'b1;
            ring_nrst_q <= 1'b1;
          end
        end
        ST_SETTLE: begin
          timer_q <= timer_q + TMR_W'(1);
          if (timer_q == SETTLE_LAST) begin
            timer_q <= '0;
            if (gate_q == '0) begin
              // Empty gate window: report the freshly cleared counter.
              state_q     <= ST_DONE;
              ring_nrst_q <= 1'b0;
              done_q      <= 1'b1;
              count_q     <= cnt_q;
              ovf_q       <= ovf_flag_q;
            end else begin
              state_q <= ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          cnt_q      <= cnt_d;
          ovf_flag_q <= ovf_flag_d;
          timer_q    <= timer_q + TMR_W'(1);
          if (timer_q == gate_last) begin
            // Latch next-state values so an edge in the last gate cycle counts.
            state_q     <= ST_DONE;
            ring_nrst_q <= 1'b0;
            done_q      <= 1'b1;
            count_q     <= cnt_d;
            ovf_q       <= ovf_flag_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          ring_nrst_q <= 1'b0;
        end
      endcase
    end
  end

  assign ring_nrst = ring_nrst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ring_osc_counter.sv
// Self-checking bench for ring_osc_counter: edge counts are predicted from the
// recorded osc_in rise times and the measurement window timing.
module tb_ring_osc_counter;

  localparam int S = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start_b;
  logic        osc_in;
  logic [11:0] gate_len;
  logic [11:0] gate_len_b;
  logic        ring_nrst, busy, done, ovf;
  logic [15:0] count;
  logic        ring_nrst_b, busy_b, done_b, ovf_b;
  logic [3:0]  count_b;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  bit rise_at [0:65535];
  int osc_hi   = 5;
  int osc_lo   = 5;
  bit osc_rand = 0;

  ring_osc_counter #(.CNT_W(16), .GATE_W(12), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .gate_len(gate_len), .osc_in(osc_in),
    .ring_nrst(ring_nrst), .busy(busy), .done(done), .count(count), .ovf(ovf)
  );

  ring_osc_counter #(.CNT_W(4), .GATE_W(12), .SETTLE_CYCLES(S)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .gate_len(gate_len_b), .osc_in(osc_in),
    .ring_nrst(ring_nrst_b), .busy(busy_b), .done(done_b), .count(count_b), .ovf(ovf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Oscillator model: changes on falling clk edges and logs every rise.
  initial begin
    int ph;
    osc_in = 1'b0;
    ph     = osc_lo;
    forever begin
      @(negedge clk);
      ph--;
      if (ph <= 0) begin
        osc_in = ~osc_in;
        if (osc_in) rise_at[cyc] = 1'b1;
        if (osc_rand) ph = int'($urandom_range(2, 7));
        else          ph = osc_in ? osc_hi : osc_lo;
      end
    end
  end

  // A rise driven in cycle c shows up as an edge pulse in cycle c+2; a start
  // sampled at edge t gives a gate window of cycles t+S .. t+S+g-1.
  function automatic int model_edges(input int t, input int g);
    int n = 0;
    for (int c = t + S - 2; c <= t + S + g - 3; c++)
      if (rise_at[c]) n++;
    return n;
  endfunction

  function automatic int limit_count(input int n, input int w);
    int mx = (1 << w) - 1;
`ifdef RING_OSC_CNT_SAT_EN
    return (n > mx) ? mx : n;
`else
    return n & mx;
`endif
  endfunction

  // Runs one measurement on the 16-bit instance and records what it observed.
  task automatic measure(input int g, input bit disturb,
                         output int t, output int done_c, output int nrst_n,
                         output int busy_fall, output int n_done,
                         output logic [15:0] cnt_o, output logic ovf_o,
                         output logic first_busy, output logic first_nrst,
                         output bit timeout);
    @(negedge clk);
    start    = 1'b1;
    gate_len = 12'(g);
    t        = cyc + 1;
    @(negedge clk);
    start      = 1'b0;
    gate_len   = 12'($urandom);
    first_busy = busy;
    first_nrst = ring_nrst;
    done_c = -1; busy_fall = -1; nrst_n = 0; n_done = 0; timeout = 1'b1;
    cnt_o  = 'x; ovf_o = 1'bx;
    for (int i = 0; i < 6000; i++) begin
      if (disturb && cyc == t + S + g / 2) begin
        start    = 1'b1;
        gate_len = 12'($urandom);
      end else begin
        start = 1'b0;
      end
      if (ring_nrst) nrst_n++;
      if (done) begin
        n_done++;
        if (done_c < 0) done_c = cyc;
        cnt_o = count;
        ovf_o = ovf;
      end
      if (done_c >= 0 && !busy && busy_fall < 0) begin
        busy_fall = cyc;
        timeout   = 1'b0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; start_b = 1'b1; gate_len = 12'd20; gate_len_b = 12'd20;
    repeat (12) begin
      @(negedge clk);
      checks++;
      if ({ring_nrst, busy, done, ovf, count, ring_nrst_b, busy_b, done_b, ovf_b, count_b} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %h expected 0",
                 {ring_nrst, busy, done, ovf, count, ring_nrst_b, busy_b, done_b, ovf_b, count_b});
      end
    end
    rst = 1'b0; start = 1'b0; start_b = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if ({ring_nrst, busy, done, ovf, count} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h expected 0", {ring_nrst, busy, done, ovf, count});
    end
  endtask

  task automatic test_basic();
    int t, dc, nn, bf, nd; logic [15:0] c; logic o, fb, fn; bit to;
    measure(100, 1'b0, t, dc, nn, bf, nd, c, o, fb, fn, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %0d expected 0", to); end
    checks++; if (dc - (t - 1) !== 117) begin errors++; $display("FAIL basic_latency: got %0d expected 117", dc - (t - 1)); end
    checks++; if (c !== 16'd10) begin errors++; $display("FAIL basic_count: got %0d expected 10", c); end
    checks++; if (c !== 16'(model_edges(t, 100))) begin errors++; $display("FAIL basic_model: got %0d expected %0d", c, model_edges(t, 100)); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %0d expected 0", o); end
    checks++; if ({fb, fn} !== 2'b11) begin errors++; $display("FAIL basic_enable: got %b expected 11", {fb, fn}); end
    checks++; if (bf !== dc + 1) begin errors++; $display("FAIL basic_busy_fall: got %0d expected %0d", bf, dc + 1); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", nd); end
    checks++; if (nn !== S + 100) begin errors++; $display("FAIL basic_nrst_cycles: got %0d expected %0d", nn, S + 100); end
  endtask

  task automatic test_gate_zero();
    int t, dc, nn, bf, nd; logic [15:0] c; logic o, fb, fn; bit to;
    measure(0, 1'b0, t, dc, nn, bf, nd, c, o, fb, fn, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL zero_timeout: got %0d expected 0", to); end
    checks++; if (dc - (t - 1) !== 17) begin errors++; $display("FAIL zero_latency: got %0d expected 17", dc - (t - 1)); end
    checks++; if ({o, c} !== 17'd0) begin errors++; $display("FAIL zero_result: got %0d/%0d expected 0/0", c, o); end
    checks++; if (nn !== S) begin errors++; $display("FAIL zero_nrst_cycles: got %0d expected %0d", nn, S); end
  endtask

  task automatic test_random();
    int t, dc, nn, bf, nd, g; logic [15:0] c; logic o, fb, fn; bit to;
    osc_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      g = int'($urandom_range(1, 300));
      measure(g, 1'b0, t, dc, nn, bf, nd, c, o, fb, fn, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand_timeout[%0d]: got %0d expected 0", k, to); end
      checks++; if (c !== 16'(model_edges(t, g))) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", k, c, model_edges(t, g)); end
      checks++; if (dc !== t + S + g) begin errors++; $display("FAIL rand_done_cycle[%0d]: got %0d expected %0d", k, dc, t + S + g); end
      checks++; if (nn !== S + g) begin errors++; $display("FAIL rand_nrst_cycles[%0d]: got %0d expected %0d", k, nn, S + g); end
    end
    osc_rand = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int t, dc, nn, bf, nd; logic [15:0] c; logic o, fb, fn; bit to;
    measure(70, 1'b1, t, dc, nn, bf, nd, c, o, fb, fn, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL ignore_timeout: got %0d expected 0", to); end
    checks++; if (dc !== t + S + 70) begin errors++; $display("FAIL ignore_done_cycle: got %0d expected %0d", dc, t + S + 70); end
    checks++; if (c !== 16'd7) begin errors++; $display("FAIL ignore_count: got %0d expected 7", c); end
    checks++; if (c !== 16'(model_edges(t, 70))) begin errors++; $display("FAIL ignore_model: got %0d expected %0d", c, model_edges(t, 70)); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL ignore_done_pulses: got %0d expected 1", nd); end
  endtask

  task automatic test_rst_mid();
    int t, dc, nn, bf, nd, n; logic [15:0] c; logic o, fb, fn; bit to;
    @(negedge clk);
    start = 1'b1; gate_len = 12'd200; t = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t + S + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, ring_nrst, done, ovf, count} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h expected 0", {busy, ring_nrst, done, ovf, count});
    end
    rst = 1'b0;
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d expected 0", n); end
    measure(60, 1'b0, t, dc, nn, bf, nd, c, o, fb, fn, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rst_fresh_timeout: got %0d expected 0", to); end
    checks++; if (c !== 16'd6) begin errors++; $display("FAIL rst_fresh_count: got %0d expected 6", c); end
    checks++; if (dc !== t + S + 60) begin errors++; $display("FAIL rst_fresh_done_cycle: got %0d expected %0d", dc, t + S + 60); end
  endtask

  task automatic test_back_to_back();
    int t1, d1, d2, b2; logic [15:0] c2; bit saw_idle, to;
    d1 = -1; d2 = -1; b2 = -1; saw_idle = 1'b0; to = 1'b1; c2 = 'x;
    @(negedge clk);
    start = 1'b1; gate_len = 12'd30; t1 = cyc + 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) begin d2 = cyc; c2 = count; end
      end
      if (d1 >= 0 && cyc > d1 && !busy) saw_idle = 1'b1;
      if (saw_idle && b2 < 0 && busy) begin b2 = cyc; start = 1'b0; end
      if (d2 >= 0) begin to = 1'b0; break; end
    end
    start = 1'b0;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL b2b_timeout: got %0d expected 0", to); end
    checks++; if (d1 !== t1 + S + 30) begin errors++; $display("FAIL b2b_first_done: got %0d expected %0d", d1, t1 + S + 30); end
    checks++; if (b2 !== d1 + 2) begin errors++; $display("FAIL b2b_retrigger: got %0d expected %0d", b2, d1 + 2); end
    checks++; if (d2 !== b2 + S + 30) begin errors++; $display("FAIL b2b_second_done: got %0d expected %0d", d2, b2 + S + 30); end
    checks++; if (c2 !== 16'(model_edges(b2, 30))) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", c2, model_edges(b2, 30)); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overflow();
    int t, g, dc, exp_c; logic [3:0] c; logic o, exp_o; bit to;
    osc_hi = 2; osc_lo = 2;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      g = (k == 0) ? 60 : 80;
      @(negedge clk);
      start_b = 1'b1; gate_len_b = 12'(g); t = cyc + 1;
      @(negedge clk);
      start_b = 1'b0;
      to = 1'b1; dc = -1; c = 'x; o = 1'bx;
      for (int i = 0; i < 300; i++) begin
        if (done_b) begin c = count_b; o = ovf_b; dc = cyc; to = 1'b0; break; end
        @(negedge clk);
      end
`ifdef RING_OSC_CNT_SAT_EN
      exp_c = 15;
`else
      exp_c = (k == 0) ? 15 : 4;
`endif
      exp_o = (k == 0) ? 1'b0 : 1'b1;
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL ovf_timeout[%0d]: got %0d expected 0", g, to); end
      checks++; if (dc !== t + S + g) begin errors++; $display("FAIL ovf_done_cycle[%0d]: got %0d expected %0d", g, dc, t + S + g); end
      checks++; if (c !== 4'(exp_c)) begin errors++; $display("FAIL ovf_count[%0d]: got %0d expected %0d", g, c, exp_c); end
      checks++; if (o !== exp_o) begin errors++; $display("FAIL ovf_flag[%0d]: got %0d expected %0d", g, o, exp_o); end
      checks++; if (c !== 4'(limit_count(model_edges(t, g), 4))) begin errors++; $display("FAIL ovf_model[%0d]: got %0d expected %0d", g, c, limit_count(model_edges(t, g), 4)); end
      repeat (3) @(negedge clk);
    end
    osc_hi = 5; osc_lo = 5;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_b = 1'b0; gate_len = '0; gate_len_b = '0;
    test_reset();
    test_basic();
    test_gate_zero();
    test_random();
    test_ignore_start();
    test_rst_mid();
    test_back_to_back();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_osc_counter.md
# ring_osc_counter

Measurement controller and frequency counter sitting directly downstream of the ring oscillator. Enables the ring via its active-low reset, lets it settle, then counts synchronized rising edges of the ring output over a programmable gate window of `clk` cycles. Latches the result with a one-cycle `done` pulse for readout logic. Single clock domain. The oscillator output is treated as an asynchronous data input.

## Interface
Parameters:
- `CNT_W`, 16: width of the edge counter and result.
- `GATE_W`, 12: width of the gate-length input.
- `SETTLE_CYCLES`, 16: `clk` cycles between ring enable and the start of counting; must be ≥ 1.

Ports:
- `clk`  in  1: block clock; all state on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a measurement; sampled only in IDLE.
- `gate_len`  in  GATE_W: gate window length in `clk` cycles; sampled with an accepted `start`.
- `osc_in`  in  1: ring oscillator output, asynchronous.
- `ring_nrst`  out  1: drives the ring's `nrst`; 1 enables oscillation.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse when `count` is updated.
- `count`  out  CNT_W: last measured edge count; holds between measurements.
- `ovf`  out  1: last measurement exceeded the CNT_W range; updated with `count`.

## Operation
- FSM states and transitions:
  - IDLE → SETTLE on `start`.
  - SETTLE → COUNT after SETTLE_CYCLES cycles.
  - COUNT → DONE after `gate_len` cycles.
  - DONE → IDLE unconditionally.
- Accepted `start` latches `gate_len`, clears the edge counter and the internal overflow flag, and zeroes the settle/gate timer.
- `start` in any state other than IDLE is ignored. `gate_len` changes after acceptance have no effect.
- `ring_nrst` is 1 in SETTLE and COUNT, and 0 in IDLE and DONE. The ring therefore runs only during a measurement.
- Edge detection:
  - `osc_in` passes through two sync flops plus one history flop.
  - `edge = s2 & ~s3`.
- The counter increments on `edge` only while in COUNT. Edges detected in SETTLE or DONE are discarded.
- `gate_len == 0`: SETTLE goes straight to DONE. Result is `count = 0`, `ovf = 0`.
- Counter overflow: see Configuration. `ovf` is set if any increment would exceed 2^CNT_W − 1.
- In DONE: `count` ← counter, `ovf` ← overflow flag, `done = 1`.
- Valid operating range: `osc_in` high and low phases each ≥ 2 `clk` periods. Faster inputs undercount; this is not detected.

## Timing
- Reset values: IDLE; `ring_nrst = 0`, `busy = 0`, `done = 0`, `count = 0`, `ovf = 0`; sync flops 0.
- `start` sampled high at edge t:
  - `busy` and `ring_nrst` go high at t+1.
  - COUNT occupies cycles t+1+SETTLE_CYCLES through t+SETTLE_CYCLES+`gate_len`.
  - `done` is high at cycle t+1+SETTLE_CYCLES+`gate_len`, and `count` is valid from that cycle.
  - `busy` falls the cycle after `done`.
- Total latency from `start` to `done`: SETTLE_CYCLES + `gate_len` + 1 cycles.
- An `osc_in` rise reaches `edge` 2–3 cycles later. The effective window is the gate window shifted by that latency, with the same length.
- Back-to-back: a `start` held high re-triggers in the IDLE cycle following DONE.
- `rst` mid-measurement returns to IDLE within one cycle and drops `ring_nrst`. `count` and `ovf` reset to 0 and no `done` pulse is produced.

## Configuration
- `RING_OSC_CNT_SAT_EN` defined: the counter saturates at 2^CNT_W − 1 and `ovf` is set.
- Undefined: the counter wraps modulo 2^CNT_W and `ovf` is set. `count` then holds the low CNT_W bits.
- `ovf` semantics are identical in both builds.

## Structure
- Package `ring_osc_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_SETTLE`, `ST_COUNT`, `ST_DONE`).
  - Default width constants for CNT_W and GATE_W.
- Sub-module `osc_edge_sync`: 2-flop synchronizer, history flop, and rising-edge pulse output. Reset to 0 on `rst`.
- Top level holds the FSM, the shared settle/gate timer, the edge counter, and the result registers.

## Test plan
- Reset with `osc_in` toggling → all outputs 0, `ring_nrst = 0`, no counting.
- `osc_in` period 10 clk (5 high/5 low), `gate_len = 100`, SETTLE_CYCLES = 16 → `done` exactly 117 cycles after `start`; `count = 10`, `ovf = 0`.
- `gate_len = 0` → `done` 17 cycles after `start`, `count = 0`; `ring_nrst` high exactly 16 cycles.
- CNT_W = 4, `osc_in` period 4, `gate_len = 80` (20 edges) → `ovf = 1`; `count = 15` with `RING_OSC_CNT_SAT_EN`, `count = 4` without.
- `start` pulsed during COUNT, plus `gate_len` changed mid-measurement → ignored; result and timing match the originally latched `gate_len`.
- `rst` asserted in COUNT → next cycle IDLE, `ring_nrst = 0`, `count = 0`, no `done` pulse; a fresh `start` then completes normally.
